// File: rtl/spi_sram_pkg.sv
// Shared types, SPI command codes and helpers for the SPI serial SRAM arbiter.
package spi_sram_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam logic [7:0]  CMD_READ  = 8'h03;
   localparam logic [7:0]  CMD_WRITE = 8'h02;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_ACK,
      ST_GAP
   } state_e;

   // Request attributes captured at grant time.
   typedef struct packed {
      logic       port_d;
      logic       we;
      logic [1:0] size;
   } req_t;

   function automatic logic [2:0] nbytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: nbytes = 3'd1;
         SZ_HALF: nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   endfunction

   // Byte 0 travels first on the wire but lives in [7:0] on the bus.
   function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
      byte_swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_sram_arbiter_if.sv
// CPU-side bus bundle: instruction-fetch port and load/store port.
interface spi_sram_arbiter_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ack;

   logic              d_req;
   logic              d_we;
   logic [1:0]        d_size;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_ack;

   modport master (
      output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
      input  if_rdata, if_ack, d_rdata, d_ack
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
      output if_rdata, if_ack, d_rdata, d_ack
   );
endinterface

// File: rtl/spi_sram_shifter.sv
// SPI mode-0 bit engine: SCLK generation, bit counting and TX/RX shift registers.
module spi_sram_shifter
   import spi_sram_pkg::*;
#(
   parameter int unsigned FRAME_W = 56,
   parameter int unsigned CLK_DIV = 1,
   parameter int unsigned LEN_W   = $clog2(FRAME_W + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame,
   input  logic [LEN_W-1:0]   len,
   input  logic               miso,
   output logic               sclk,
   output logic               mosi,
   output logic               done_c,
   output logic [DATA_W-1:0]  rx_c
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;

   logic                active;
   logic [DIV_W-1:0]    div_cnt;
   logic [LEN_W-1:0]    bit_cnt;
   logic [LEN_W-1:0]    len_q;
   logic [FRAME_W-1:0]  tx_sr;
   logic [DATA_W-2:0]   rx_sr;
   logic                phase_end_c;

   assign phase_end_c = active && (div_cnt == DIV_W'(CLK_DIV - 1));
   // Last cycle of the final high phase; the arbiter acks on the following edge.
   assign done_c      = phase_end_c && sclk && ((bit_cnt + LEN_W'(1)) == len_q);
   assign rx_c        = {rx_sr, miso};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         len_q   <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
      end else if (start) begin
         active  <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
         len_q   <= len;
         tx_sr   <= frame;
         sclk    <= 1'b0;
         mosi    <= frame[FRAME_W-1];
      end else if (active) begin
         if (!phase_end_c) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end else begin
            div_cnt <= '0;
            if (!sclk) begin
               sclk <= 1'b1;
            end else begin
               sclk  <= 1'b0;
               rx_sr <= rx_c[DATA_W-2:0];
               if (done_c) begin
                  active <= 1'b0;
                  mosi   <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + LEN_W'(1);
                  tx_sr   <= tx_sr << 1;
                  mosi    <= tx_sr[FRAME_W-2];
               end
            end
         end
      end
   end

endmodule

// File: rtl/spi_sram_arbiter.sv
// Round-robin arbiter sharing one SPI serial SRAM between the fetch and load/store ports.
module spi_sram_arbiter
   import spi_sram_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned CLK_DIV = 1,
   parameter int unsigned CS_GAP  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   spi_sram_arbiter_if.slave  bus,
   output logic               spi_cs_n,
   output logic               spi_sclk,
   output logic               spi_mosi,
   input  logic               spi_miso,
   output logic               busy
);

   localparam int unsigned FRAME_W = 8 + ADDR_W + DATA_W;
   localparam int unsigned LEN_W   = $clog2(FRAME_W + 1);
   localparam int unsigned GAP_W   = $clog2(CS_GAP) + 1;

   state_e              state;
   req_t                req;
   logic                rr_last_d;
   logic [GAP_W-1:0]    gap_cnt;

   logic                grant_c;
   logic                grant_d_c;
   logic [FRAME_W-1:0]  frame_c;
   logic [LEN_W-1:0]    len_c;
   logic                done_c;
   logic [DATA_W-1:0]   rx_c;
   logic [DATA_W-1:0]   rdata_c;

   // Arbitration and frame build; the shifter captures the frame at grant.
   always_comb begin
      grant_c   = 1'b0;
      grant_d_c = 1'b0;
      frame_c   = '0;
      len_c     = '0;
      if (state == ST_IDLE) begin
         if (bus.if_req && (!bus.d_req || rr_last_d)) begin
            grant_c = 1'b1;
         end else if (bus.d_req) begin
            grant_c   = 1'b1;
            grant_d_c = 1'b1;
         end
      end
      if (grant_d_c) begin
         frame_c = {(bus.d_we ? CMD_WRITE : CMD_READ), bus.d_addr,
                    (bus.d_we ? byte_swap(bus.d_wdata) : DATA_W'(0))};
         len_c   = LEN_W'(8 + ADDR_W) + LEN_W'({nbytes(bus.d_size), 3'b000});
      end else begin
         frame_c = {CMD_READ, bus.if_addr, DATA_W'(0)};
         len_c   = LEN_W'(FRAME_W);
      end
   end

   // Only the trailing data-phase bits of the receive stream are kept.
   always_comb begin
      rdata_c = byte_swap(rx_c);
      case (nbytes(req.size))
         3'd1:    rdata_c = {24'h0, rx_c[7:0]};
         3'd2:    rdata_c = {16'h0, rx_c[7:0], rx_c[15:8]};
         default: ;
      endcase
   end

   spi_sram_shifter #(
      .FRAME_W (FRAME_W),
      .CLK_DIV (CLK_DIV),
      .LEN_W   (LEN_W)
   ) u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (grant_c),
      .frame  (frame_c),
      .len    (len_c),
      .miso   (spi_miso),
      .sclk   (spi_sclk),
      .mosi   (spi_mosi),
      .done_c (done_c),
      .rx_c   (rx_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         req          <= '0;
         rr_last_d    <= 1'b1;
         gap_cnt      <= '0;
         spi_cs_n     <= 1'b1;
         busy         <= 1'b0;
         bus.if_ack   <= 1'b0;
         bus.d_ack    <= 1'b0;
         bus.if_rdata <= '0;
         bus.d_rdata  <= '0;
      end else begin
         bus.if_ack <= 1'b0;
         bus.d_ack  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_c) begin
                  state      <= ST_SHIFT;
                  spi_cs_n   <= 1'b0;
                  busy       <= 1'b1;
                  rr_last_d  <= grant_d_c;
                  req.port_d <= grant_d_c;
                  req.we     <= grant_d_c & bus.d_we;
                  req.size   <= grant_d_c ? bus.d_size : SZ_WORD;
               end
            end
            ST_SHIFT: begin
               if (done_c) begin
                  state    <= ST_ACK;
                  spi_cs_n <= 1'b1;
                  if (req.port_d) begin
                     bus.d_ack <= 1'b1;
                     if (!req.we) begin
                        bus.d_rdata <= rdata_c;
                     end
                  end else begin
                     bus.if_ack   <= 1'b1;
                     bus.if_rdata <= rdata_c;
                  end
               end
            end
            ST_ACK: begin
               state   <= ST_GAP;
               gap_cnt <= '0;
            end
            ST_GAP: begin
               if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sram_arbiter.sv
// Directed bench for spi_sram_arbiter: CLK_DIV=1 instance (g_dut[0]) and CLK_DIV=3 instance (g_dut[1]).
module tb_spi_sram_arbiter;

   localparam int unsigned ADDR_W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned CD = (g == 1) ? 3 : 1;

      spi_sram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
      logic cs_n, sclk, mosi, busy;
      logic miso = 1'b0;

      spi_sram_arbiter #(.ADDR_W(ADDR_W), .CLK_DIV(CD), .CS_GAP(2)) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .bus      (bus),
         .spi_cs_n (cs_n),
         .spi_sclk (sclk),
         .spi_mosi (mosi),
         .spi_miso (miso),
         .busy     (busy)
      );

      // SPI SRAM model: written bytes in mem, preset contents in rom().
      logic [7:0]  mem [logic [15:0]];
      logic [7:0]  sh   = 8'h00;
      logic [7:0]  cmd  = 8'h00;
      logic [7:0]  rbyte;
      logic [15:0] addr = 16'h0000;
      int          bitn = 0;
      int          last_bits = 0;

      function automatic logic [7:0] rom(input logic [15:0] a);
         case (a)
            16'h1234: rom = 8'hEF;
            16'h1235: rom = 8'hBE;
            16'h1236: rom = 8'hAD;
            16'h1237: rom = 8'hDE;
            16'h0010: rom = 8'h34;
            16'h0011: rom = 8'h12;
            default:  rom = 8'h00;
         endcase
      endfunction

      always @(posedge sclk or posedge cs_n) begin
         if (cs_n) begin
            last_bits = bitn;
            bitn      = 0;
         end else begin
            sh = {sh[6:0], mosi};
            bitn++;
            if (bitn == 8) cmd = sh;
            else if (bitn == 16) addr[15:8] = sh;
            else if (bitn == 24) addr[7:0] = sh;
            else if (bitn > 24 && (bitn % 8) == 0 && cmd == 8'h02)
               mem[addr + 16'((bitn - 32) / 8)] = sh;
         end
      end

      always @(negedge sclk) begin
         if (!cs_n && bitn >= 24) begin
            if (mem.exists(addr + 16'((bitn - 24) / 8)) != 0)
               rbyte = mem[addr + 16'((bitn - 24) / 8)];
            else
               rbyte = rom(addr + 16'((bitn - 24) / 8));
            miso = rbyte[3'(7 - ((bitn - 24) % 8))];
         end
      end
   end

   typedef struct {
      logic        port_d;
      logic        we;
      logic [1:0]  size;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [7:0]  exp_cmd;
      int          exp_bits;
      int          exp_lat;
      logic [31:0] exp_if;
      logic [31:0] exp_d;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_idle0();
      for (int i = 0; i < 50 && g_dut[0].busy; i++) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   k     = 0;
      logic seen  = 1'b0;
      logic wrong = 1'b0;
      wait_idle0();
      @(negedge clk);
      if (v.port_d) begin
         g_dut[0].bus.d_we    = v.we;
         g_dut[0].bus.d_size  = v.size;
         g_dut[0].bus.d_addr  = v.addr;
         g_dut[0].bus.d_wdata = v.wdata;
         g_dut[0].bus.d_req   = 1'b1;
      end else begin
         g_dut[0].bus.if_addr = v.addr;
         g_dut[0].bus.if_req  = 1'b1;
      end
      while (!seen && k < 1000) begin
         @(negedge clk);
         k++;
         if (g_dut[0].bus.if_ack || g_dut[0].bus.d_ack) begin
            seen  = 1'b1;
            wrong = v.port_d ? g_dut[0].bus.if_ack : g_dut[0].bus.d_ack;
         end
      end
      g_dut[0].bus.if_req = 1'b0;
      g_dut[0].bus.d_req  = 1'b0;
      chk({tag, ".ack_port"}, 32'(wrong), 32'd0);
      chk({tag, ".ack_cycle"}, 32'(k), 32'(v.exp_lat));
      chk({tag, ".if_rdata"}, g_dut[0].bus.if_rdata, v.exp_if);
      chk({tag, ".d_rdata"}, g_dut[0].bus.d_rdata, v.exp_d);
      chk({tag, ".cmd"}, 32'(g_dut[0].cmd), 32'(v.exp_cmd));
      chk({tag, ".addr"}, 32'(g_dut[0].addr), 32'(v.addr));
      chk({tag, ".bits"}, 32'(g_dut[0].last_bits), 32'(v.exp_bits));
      @(negedge clk);
      chk({tag, ".ack_width"}, 32'({g_dut[0].bus.if_ack, g_dut[0].bus.d_ack}), 32'd0);
   endtask

   initial begin
      logic [3:0] ord;
      int nack, nfall, hi_run, min_gap, k, run, nchg, bad;
      logic prev_cs, prev_sclk;

      // port_d we size addr wdata | cmd bits lat if_rdata d_rdata
      vecs[0] = '{1'b0, 1'b0, 2'b10, 16'h1234, 32'h0,        8'h03, 56, 113, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 2'b00, 16'h00FF, 32'h000000A5, 8'h02, 32, 65,  32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 2'b00, 16'h00FF, 32'h0,        8'h03, 32, 65,  32'hDEADBEEF, 32'h000000A5};
      vecs[3] = '{1'b1, 1'b0, 2'b11, 16'h1234, 32'h0,        8'h03, 56, 113, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[4] = '{1'b1, 1'b1, 2'b01, 16'h0020, 32'hCAFE1357, 8'h02, 40, 81,  32'hDEADBEEF, 32'hDEADBEEF};
      vecs[5] = '{1'b0, 1'b0, 2'b10, 16'h0020, 32'h0,        8'h03, 56, 113, 32'h00001357, 32'hDEADBEEF};
      vecs[6] = '{1'b1, 1'b0, 2'b01, 16'h1236, 32'h0,        8'h03, 40, 81,  32'h00001357, 32'h0000DEAD};

      g_dut[0].bus.if_req = 1'b0; g_dut[0].bus.if_addr = '0;
      g_dut[0].bus.d_req = 1'b0; g_dut[0].bus.d_we = 1'b0; g_dut[0].bus.d_size = 2'b00;
      g_dut[0].bus.d_addr = '0; g_dut[0].bus.d_wdata = '0;
      g_dut[1].bus.if_req = 1'b0; g_dut[1].bus.if_addr = '0;
      g_dut[1].bus.d_req = 1'b0; g_dut[1].bus.d_we = 1'b0; g_dut[1].bus.d_size = 2'b00;
      g_dut[1].bus.d_addr = '0; g_dut[1].bus.d_wdata = '0;

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.pins0", 32'({g_dut[0].cs_n, g_dut[0].sclk, g_dut[0].mosi, g_dut[0].busy,
                             g_dut[0].bus.if_ack, g_dut[0].bus.d_ack}), 32'b100000);
      chk("reset.if_rdata0", g_dut[0].bus.if_rdata, 32'h0);
      chk("reset.d_rdata0", g_dut[0].bus.d_rdata, 32'h0);
      chk("reset.pins1", 32'({g_dut[1].cs_n, g_dut[1].sclk, g_dut[1].mosi, g_dut[1].busy,
                             g_dut[1].bus.if_ack, g_dut[1].bus.d_ack}), 32'b100000);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Both ports requesting continuously from reset
      @(negedge clk);
      rst_n = 1'b0;
      g_dut[0].bus.if_addr = 16'h1234; g_dut[0].bus.if_req = 1'b1;
      g_dut[0].bus.d_we = 1'b0; g_dut[0].bus.d_size = 2'b00;
      g_dut[0].bus.d_addr = 16'h00FF; g_dut[0].bus.d_req = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ord = 4'h0; nack = 0; nfall = 0; hi_run = 0; min_gap = 1000; k = 0; prev_cs = 1'b1;
      while (nack < 4 && k < 2000) begin
         @(negedge clk);
         k++;
         if (prev_cs && !g_dut[0].cs_n) begin
            nfall++;
            if (nfall > 1 && hi_run < min_gap) min_gap = hi_run;
         end
         hi_run  = g_dut[0].cs_n ? hi_run + 1 : 0;
         prev_cs = g_dut[0].cs_n;
         if (g_dut[0].bus.if_ack) begin ord = {ord[2:0], 1'b0}; nack++; end
         if (g_dut[0].bus.d_ack)  begin ord = {ord[2:0], 1'b1}; nack++; end
      end
      g_dut[0].bus.if_req = 1'b0;
      g_dut[0].bus.d_req  = 1'b0;
      chk("rr.order", 32'(ord), 32'b0101);
      chk("rr.acks", 32'(nack), 32'd4);
      chk("rr.cs_falls", 32'(nfall), 32'd4);
      chk("rr.min_gap_ok", 32'(min_gap >= 2), 32'd1);
      chk("rr.if_rdata", g_dut[0].bus.if_rdata, 32'hDEADBEEF);
      chk("rr.d_rdata", g_dut[0].bus.d_rdata, 32'h000000A5);
      wait_idle0();

      // Reset during the 20th shift bit
      @(negedge clk);
      g_dut[0].bus.if_addr = 16'h1234; g_dut[0].bus.if_req = 1'b1;
      repeat (39) @(negedge clk);
      chk("midrst.in_shift", 32'({g_dut[0].cs_n, g_dut[0].busy}), 32'b01);
      chk("midrst.bits_seen", 32'(g_dut[0].bitn), 32'd19);
      rst_n = 1'b0;
      g_dut[0].bus.if_req = 1'b0;
      @(negedge clk);
      chk("midrst.pins", 32'({g_dut[0].cs_n, g_dut[0].sclk, g_dut[0].busy,
                             g_dut[0].bus.if_ack, g_dut[0].bus.d_ack}), 32'b10000);
      chk("midrst.if_rdata", g_dut[0].bus.if_rdata, 32'h0);
      rst_n = 1'b1;
      nack = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (g_dut[0].bus.if_ack || g_dut[0].bus.d_ack) nack++;
      end
      chk("midrst.no_ack", 32'(nack), 32'd0);
      run_vec(vecs[0], "midrst.refetch");

      // CLK_DIV=3 half-word read on the second instance
      @(negedge clk);
      g_dut[1].bus.d_we = 1'b0; g_dut[1].bus.d_size = 2'b01;
      g_dut[1].bus.d_addr = 16'h0010; g_dut[1].bus.d_req = 1'b1;
      k = 0; run = 0; nchg = 0; bad = 0; prev_sclk = 1'b0; nack = 0;
      while (nack == 0 && k < 1000) begin
         @(negedge clk);
         k++;
         if (!g_dut[1].cs_n) begin
            if (run > 0 && g_dut[1].sclk != prev_sclk) begin
               nchg++;
               if (run != 3) bad++;
               run = 1;
            end else begin
               run++;
            end
         end else begin
            run = 0;
         end
         prev_sclk = g_dut[1].sclk;
         if (g_dut[1].bus.d_ack || g_dut[1].bus.if_ack) nack++;
      end
      g_dut[1].bus.d_req = 1'b0;
      chk("div3.ack_cycle", 32'(k), 32'd241);
      chk("div3.d_ack", 32'(g_dut[1].bus.d_ack), 32'd1);
      chk("div3.d_rdata", g_dut[1].bus.d_rdata, 32'h00001234);
      chk("div3.sclk_edges", 32'(nchg), 32'd79);
      chk("div3.bad_phases", 32'(bad), 32'd0);
      chk("div3.bits", 32'(g_dut[1].last_bits), 32'd40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
